// File: rtl/mmio_uart_tx_pkg.sv
// mmio_uart_tx_pkg: register offsets, STATUS bit positions and TX FSM encodings for the UART transmitter
package mmio_uart_tx_pkg;
  localparam logic [1:0] UART_TXDATA  = 2'd0;
  localparam logic [1:0] UART_STATUS  = 2'd1;
  localparam logic [1:0] UART_BAUDDIV = 2'd2;
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction
endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// sync_fifo: first-word fall-through FIFO; a push while full is legal only together with a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, push};
    rptr_d = rptr_q + {{AW{1'b0}}, pop};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wptr_q[AW-1:0]] <= din;
  assign dout  = mem_q[rptr_q[AW-1:0]];
  assign empty = wptr_q == rptr_q;
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO, baud divider and registered read port
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int BAUD_DIV_RST = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [3:0]  MemWrite_EN,
  input  logic [31:0] MemAddr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        uart_txd
);
  logic [1:0] state_q, state_d, off;
  logic [15:0] baud_q, baud_d, div_l_q, div_l_d, cnt_q, cnt_d, new_div;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, fifo_dout;
  logic [31:0] rd_q, rd_d;
  logic [3:0] status;
  logic ovf_q, ovf_d, full, empty, busy, tick, pop, push_req, push, ovf_clr;
  logic unused;
  assign unused   = ^{MemAddr[31:4], MemAddr[1:0], WriteData[31:16]};
  assign off      = MemAddr[3:2];
  assign busy     = state_q != S_IDLE;
  assign tick     = cnt_q == 16'd0;
  assign new_div  = eff_div(baud_q);
  // STOP hands straight to the next START when data is waiting, so frames run back to back
  assign pop      = !empty && (state_q == S_IDLE || (state_q == S_STOP && tick));
  assign push_req = sel && off == UART_TXDATA && MemWrite_EN[0];
  assign push     = push_req && (!full || pop);
  assign ovf_clr  = sel && off == UART_STATUS && MemWrite_EN[0] && WriteData[ST_OVF];
  assign uart_txd = state_q == S_START ? 1'b0 : state_q == S_DATA ? shift_q[0] : 1'b1;
  assign ReadData = rd_q;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .din(WriteData[7:0]), .pop(pop),
    .dout(fifo_dout), .full(full), .empty(empty)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? div_l_q - 16'd1 : cnt_q - 16'd1;
    div_l_d = div_l_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    if (pop) begin
      state_d = S_START;
      shift_d = fifo_dout;
      div_l_d = new_div;
      cnt_d   = new_div - 16'd1;
    end else if (state_q == S_IDLE) begin
      cnt_d = cnt_q;
    end else if (tick) begin
      state_d = state_q == S_START ? S_DATA : state_q == S_STOP ? S_IDLE : bit_q == 3'd7 ? S_STOP : S_DATA;
      bit_d   = state_q == S_DATA ? bit_q + 3'd1 : 3'd0;
      shift_d = state_q == S_DATA ? shift_q >> 1 : shift_q;
    end
  end
  always_comb begin
    baud_d = baud_q;
    if (sel && off == UART_BAUDDIV && MemWrite_EN[0]) baud_d[7:0] = WriteData[7:0];
    if (sel && off == UART_BAUDDIV && MemWrite_EN[1]) baud_d[15:8] = WriteData[15:8];
    ovf_d = (push_req && !push) || (ovf_q && !ovf_clr);
    status = 4'd0;
    status[ST_FULL]  = full;
    status[ST_EMPTY] = empty;
    status[ST_BUSY]  = busy;
    status[ST_OVF]   = ovf_q;
    rd_d = !sel ? 32'd0 : off == UART_STATUS ? {28'd0, status} : off == UART_BAUDDIV ? {16'd0, baud_q} : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      div_l_q <= 16'd1;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      baud_q  <= 16'(BAUD_DIV_RST);
      ovf_q   <= 1'b0;
      rd_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_l_q <= div_l_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      ovf_q   <= ovf_d;
      rd_q    <= rd_d;
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: scoreboard bench; bus reads and serial frames are checked by independent monitors
module tb_mmio_uart_tx;
  logic clk = 1'b0, reset = 1'b1, sel = 1'b0, txd;
  logic [3:0] en = 4'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0, rdata;
  int n_tot = 0, n_bad = 0, cyc = 0, tb_div = 434;
  logic [31:0] rd_q[$];
  string rd_name[$];
  logic [7:0] tx_q[$];
  int starts[$];
  logic rd_req = 1'b0, rd_pend = 1'b0;
  logic rx_act = 1'b0, rx_bad = 1'b0, rx_got = 1'b0, rx_exp = 1'b0;
  int rx_cnt = 0, rx_div = 1, rx_at = 0;
  logic [9:0] rx_frame = 10'h3FF;

  mmio_uart_tx #(.FIFO_DEPTH(16), .BAUD_DIV_RST(434)) dut (
    .clk(clk), .reset(reset), .sel(sel), .MemWrite_EN(en), .MemAddr(addr),
    .WriteData(wdata), .ReadData(rdata), .uart_txd(txd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_pend <= rd_req;

  always @(negedge clk) begin : mon_rd
    logic [31:0] e;
    string nm;
    if (rd_pend) begin
      n_tot++;
      if (rd_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_unexpected got=%h", rdata);
      end else begin
        e  = rd_q.pop_front();
        nm = rd_name.pop_front();
        if (rdata !== e) begin
          n_bad++;
          $display("FAIL %s got=%h want=%h", nm, rdata, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (reset) rx_act = 1'b0;
    else begin
      if (!rx_act && txd === 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
        rx_bad = 1'b0;
        rx_div = tb_div;
        starts.push_back(cyc);
        rx_frame = (tx_q.size() == 0) ? 10'h3FF : {1'b1, tx_q.pop_front(), 1'b0};
      end
      if (rx_act) begin
        if (txd !== rx_frame[rx_cnt / rx_div] && !rx_bad) begin
          rx_bad = 1'b1;
          rx_at  = rx_cnt;
          rx_got = txd;
          rx_exp = rx_frame[rx_cnt / rx_div];
        end
        rx_cnt++;
        if (rx_cnt == 10 * rx_div) begin
          rx_act = 1'b0;
          n_tot++;
          if (rx_bad) begin
            n_bad++;
            $display("FAIL rx_frame byte=%h cycle_in_frame=%0d got=%b want=%b", rx_frame[8:1], rx_at, rx_got, rx_exp);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tot++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic op(input logic s, input logic [1:0] off, input logic [3:0] e, input logic [31:0] d);
    #1;
    sel = s;
    addr = {28'd0, off, 2'b00};
    en = e;
    wdata = d;
    rd_req = (e == 4'd0);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    #1;
    sel = 1'b0;
    en = 4'd0;
    rd_req = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic rd(input logic [1:0] off, input logic [31:0] e, input string nm);
    rd_q.push_back(e);
    rd_name.push_back(nm);
    op(1'b1, off, 4'd0, 32'd0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    tx_q.push_back(b);
    op(1'b1, 2'd0, 4'b0001, {24'hABCDEF, b});
  endtask

  task automatic set_div(input logic [15:0] d);
    op(1'b1, 2'd2, 4'b0011, {16'hFFFF, d});
    tb_div = (d == 16'd0) ? 1 : int'(d);
  endtask

  task automatic wait_drain(input int limit, input string nm);
    int k = 0;
    while ((tx_q.size() != 0 || rx_act) && k < limit) begin
      @(posedge clk);
      k++;
    end
    n_tot++;
    if (k >= limit) begin
      n_bad++;
      $display("FAIL %s timeout pending=%0d want=0", nm, tx_q.size());
    end
  endtask

  task automatic chk_gaps(input int n, input int want, input string nm);
    int bad = 0;
    for (int i = 1; i < starts.size(); i++) if (starts[i] - starts[i-1] != want) bad++;
    n_tot++;
    if (starts.size() != n || bad != 0) begin
      n_bad++;
      $display("FAIL %s frames=%0d want=%0d bad_gaps=%0d want=0 (period %0d)", nm, starts.size(), n, bad, want);
    end
  endtask

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog cycles=%0d", cyc);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk) chk("txd_idle_rst", {31'd0, txd}, 32'd1);
    @(posedge clk);
    rd(2'd1, 32'h2, "status_rst");
    rd(2'd2, 32'd434, "baud_rst");
    rd(2'd0, 32'd0, "txdata_rd");
    rd(2'd3, 32'd0, "rsvd_rd");
    idle(2);
    set_div(16'd4);
    push_byte(8'hA5);
    rd(2'd1, 32'h0, "status_queued");
    rd(2'd1, 32'h6, "status_busy");
    idle(1);
    wait_drain(100, "drain_a5");
    idle(2);
    rd(2'd1, 32'h2, "status_after_a5");
    idle(2);
    set_div(16'd20);
    starts.delete();
    push_byte(8'h10);
    idle(3);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) push_byte(8'h11 + 8'(i));
      else op(1'b1, 2'd0, 4'b0001, 32'h21);
    end
    rd(2'd1, 32'hD, "status_ovf");
    op(1'b1, 2'd1, 4'b0001, 32'h8);
    rd(2'd1, 32'h5, "status_ovf_clr");
    idle(1);
    while (cyc < starts[0] + 200 - 2) @(posedge clk);
    push_byte(8'h22);
    rd(2'd1, 32'h5, "status_push_on_pop");
    idle(1);
    wait_drain(4000, "drain_burst");
    chk_gaps(18, 200, "gap_burst");
    idle(2);
    rd(2'd1, 32'h2, "status_burst_done");
    idle(2);
    set_div(16'd8);
    push_byte(8'h3C);
    idle(40);
    #1;
    reset = 1'b1;
    tx_q.delete();
    tb_div = 434;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk) chk("txd_after_rst", {31'd0, txd}, 32'd1);
    @(posedge clk);
    rd(2'd1, 32'h2, "status_after_rst");
    rd(2'd2, 32'd434, "baud_after_rst");
    set_div(16'd3);
    push_byte(8'h5A);
    idle(1);
    wait_drain(100, "drain_5a");
    idle(2);
    op(1'b1, 2'd0, 4'b0010, 32'h77);
    op(1'b0, 2'd0, 4'b0001, 32'h66);
    op(1'b0, 2'd2, 4'b0011, 32'h55);
    idle(3);
    rd(2'd1, 32'h2, "status_no_push");
    rd(2'd2, 32'd3, "baud_unsel_wr");
    rd_q.push_back(32'd0);
    rd_name.push_back("rd_unsel");
    op(1'b0, 2'd2, 4'd0, 32'd0);
    op(1'b1, 2'd2, 4'b0001, 32'h09);
    op(1'b1, 2'd2, 4'b0010, 32'h0100);
    op(1'b1, 2'd2, 4'b1100, 32'hFFFF_0000);
    rd(2'd2, 32'h109, "baud_lanes");
    set_div(16'd0);
    rd(2'd2, 32'd0, "baud_zero");
    starts.delete();
    push_byte(8'h81);
    push_byte(8'hC3);
    idle(1);
    wait_drain(100, "drain_div0");
    chk_gaps(2, 10, "gap_div0");
    idle(3);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
